// File: rtl/cmd_control.sv
// Host-side SD command controller: frames index/argument with CRC7, hands the
// frame to the CMD PHY, captures the 48-bit response and checks its index.
module cmd_control (
  input  logic        iClock_host,
  input  logic        iReset,
  input  logic        iNew_command,
  input  logic [5:0]  iCmd_index,
  input  logic [31:0] iCmd_argument,
  input  logic [47:0] iCmd_in,
  input  logic        iStrobe_in,
  input  logic        iAck_in,
  input  logic        iTimeout_enable,
  input  logic        iTimeout,
  output logic        oIdle_out,
  output logic        oStrobe_out,
  output logic        oAck_out,
  output logic        oCommand_complete,
  output logic [47:0] oResponse,
  output logic        oCommand_index_error,
  output logic [47:0] oCmd_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ACK, S_WAIT_RESP, S_WAIT_RELEASE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [47:0] cmd_q, cmd_d;
  logic [47:0] resp_q, resp_d;
  logic        strobe_q, strobe_d;
  logic        ack_q, ack_d;
  logic        cmpl_q, cmpl_d;
  logic        err_q, err_d;
  logic        tmo_hit;

  // Serial CRC7 (x^7+x^3+1), zero seed, MSB first over start..argument bits.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    hdr = {2'b01, idx, arg};
    return {hdr, crc7(hdr), 1'b1};
  endfunction

  assign tmo_hit = iTimeout_enable && iTimeout &&
                   (state_q == S_WAIT_ACK || state_q == S_WAIT_RESP || state_q == S_WAIT_RELEASE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    resp_d   = resp_q;
    strobe_d = strobe_q;
    ack_d    = ack_q;
    cmpl_d   = cmpl_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: if (iNew_command) begin
        idx_d    = iCmd_index;
        cmd_d    = build_frame(iCmd_index, iCmd_argument);
        strobe_d = 1'b1;
        resp_d   = '0;
        err_d    = 1'b0;
        cmpl_d   = 1'b0;
        state_d  = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (iAck_in) begin
        strobe_d = 1'b0;
        state_d  = S_WAIT_RESP;
      end
      S_WAIT_RESP: if (iStrobe_in) begin
        resp_d  = iCmd_in;
        ack_d   = 1'b1;
        err_d   = (iCmd_in[45:40] != idx_q);
        state_d = S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: if (!iStrobe_in) begin
        ack_d   = 1'b0;
        cmpl_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        cmpl_d = 1'b1;
        if (!iNew_command) begin
          cmpl_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Timeout wins over any handshake seen on the same edge; response is kept.
    if (tmo_hit) begin
      resp_d   = resp_q;
      strobe_d = 1'b0;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      cmpl_d   = 1'b1;
      state_d  = S_DONE;
    end
  end

  always_ff @(posedge iClock_host or negedge iReset) begin
    if (!iReset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cmd_q    <= '0;
      resp_q   <= '0;
      strobe_q <= 1'b0;
      ack_q    <= 1'b0;
      cmpl_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cmd_q    <= cmd_d;
      resp_q   <= resp_d;
      strobe_q <= strobe_d;
      ack_q    <= ack_d;
      cmpl_q   <= cmpl_d;
      err_q    <= err_d;
    end
  end

  assign oIdle_out            = (state_q == S_IDLE);
  assign oStrobe_out          = strobe_q;
  assign oAck_out             = ack_q;
  assign oCommand_complete    = cmpl_q;
  assign oResponse            = resp_q;
  assign oCommand_index_error = err_q;
  assign oCmd_out             = cmd_q;

endmodule

// File: tb/tb_cmd_control.sv
// Bench for cmd_control: frame vectors table, handshake sequences, timeout
// corners and randomized commands against a polynomial-division CRC model.
module tb_cmd_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_cmd;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [47:0] cmd_in;
  logic        strobe_in, ack_in, tmo_en, tmo;
  logic        idle, strobe_out, ack_out, complete, idx_err;
  logic [47:0] resp, cmd_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cmd_control dut (
    .iClock_host(clk), .iReset(rst_n), .iNew_command(new_cmd),
    .iCmd_index(cmd_idx), .iCmd_argument(cmd_arg), .iCmd_in(cmd_in),
    .iStrobe_in(strobe_in), .iAck_in(ack_in), .iTimeout_enable(tmo_en),
    .iTimeout(tmo), .oIdle_out(idle), .oStrobe_out(strobe_out),
    .oAck_out(ack_out), .oCommand_complete(complete), .oResponse(resp),
    .oCommand_index_error(idx_err), .oCmd_out(cmd_out)
  );

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
  } vec_t;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // CRC as remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [46:0] r;
    logic [39:0] m;
    m = {2'b01, idx, arg};
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return {m, r[6:0], 1'b1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp_frame);
    cmd_idx = idx; cmd_arg = arg; new_cmd = 1'b1;
    step();
    chk("start_strobe", strobe_out, 1);
    chk("start_idle", idle, 0);
    chk("start_frame", cmd_out, exp_frame);
    chk("start_complete_clr", complete, 0);
  endtask

  task automatic do_ack();
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    chk("ack_strobe_low", strobe_out, 0);
  endtask

  task automatic do_resp(input logic [47:0] r, input logic exp_err);
    cmd_in = r; strobe_in = 1'b1;
    step();
    chk("resp_ack", ack_out, 1);
    chk("resp_capture", resp, r);
    chk("resp_idx_err", idx_err, exp_err);
    strobe_in = 1'b0;
    step();
    chk("release_ack", ack_out, 0);
    chk("release_complete", complete, 1);
  endtask

  task automatic finish_cmd();
    new_cmd = 1'b0;
    step();
    chk("done_idle", idle, 1);
    chk("done_complete_clr", complete, 0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{6'd0,  32'h0000_0000, 48'h4000_0000_0095};
    vecs[1] = '{6'd8,  32'h0000_01AA, 48'h4800_0001_AA87};
    vecs[2] = '{6'd17, 32'h0000_0000, 48'h5100_0000_0055};
    vecs[3] = '{6'd55, 32'h0000_0000, model_frame(6'd55, 32'h0)};

    rst_n = 1'b0; new_cmd = 0; cmd_idx = 0; cmd_arg = 0; cmd_in = 0;
    strobe_in = 0; ack_in = 0; tmo_en = 0; tmo = 0;
    #1;
    chk("rst_idle", idle, 1);
    chk("rst_strobe", strobe_out, 0);
    chk("rst_ack", ack_out, 0);
    chk("rst_complete", complete, 0);
    chk("rst_resp", resp, 0);
    chk("rst_err", idx_err, 0);
    chk("rst_cmd_out", cmd_out, 0);
    #13 rst_n = 1'b1;
    step();
    chk("post_rst_idle", idle, 1);

    // Table of known frames, each through a full matching-index transaction
    for (int i = 0; i < 4; i++) begin
      chk("model_vs_table", model_frame(vecs[i].idx, vecs[i].arg), vecs[i].frame);
      start_cmd(vecs[i].idx, vecs[i].arg, vecs[i].frame);
      do_ack();
      do_resp({2'b00, vecs[i].idx, 40'h00_0001_AA13}, 1'b0);
      finish_cmd();
    end

    // CMD8 spec response and CMD17 with wrong response index
    start_cmd(6'd8, 32'h1AA, 48'h4800_0001_AA87);
    do_ack();
    do_resp(48'h0800_0001_AA13, 1'b0);
    finish_cmd();
    start_cmd(6'd17, 32'h0, 48'h5100_0000_0055);
    do_ack();
    do_resp({2'b00, 6'd18, 40'h0000_0009_01}, 1'b1);
    finish_cmd();

    // Reset mid WAIT_RESP
    start_cmd(6'd3, 32'h1234, model_frame(6'd3, 32'h1234));
    do_ack();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_idle", idle, 1);
    chk("midrst_strobe", strobe_out, 0);
    chk("midrst_ack", ack_out, 0);
    chk("midrst_cmd_out", cmd_out, 0);
    new_cmd = 1'b0;
    #3 rst_n = 1'b1;
    step();

    // Timeout in WAIT_RESP while a response strobe arrives on the same edge
    start_cmd(6'd2, 32'h0, model_frame(6'd2, 32'h0));
    do_ack();
    tmo_en = 1; tmo = 1; strobe_in = 1; cmd_in = 48'h0200_0000_0001;
    step();
    tmo = 0; tmo_en = 0; strobe_in = 0;
    chk("tmo_complete", complete, 1);
    chk("tmo_resp", resp, 0);
    chk("tmo_ack", ack_out, 0);
    chk("tmo_err", idx_err, 0);
    finish_cmd();

    // Timeout priority over ack in WAIT_ACK
    start_cmd(6'd9, 32'h5, model_frame(6'd9, 32'h5));
    tmo_en = 1; tmo = 1; ack_in = 1;
    step();
    tmo = 0; tmo_en = 0; ack_in = 0;
    chk("tmo_ack_complete", complete, 1);
    chk("tmo_ack_strobe", strobe_out, 0);
    finish_cmd();

    // Timeout disabled: controller keeps waiting
    start_cmd(6'd13, 32'hA5A5_0000, model_frame(6'd13, 32'hA5A5_0000));
    do_ack();
    tmo = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("notmo_complete", complete, 0);
      chk("notmo_idle", idle, 0);
    end
    tmo = 0;
    // Index/argument changes after start must not matter; hold request high
    cmd_idx = 6'd40; cmd_arg = 32'hFFFF_FFFF;
    do_resp({2'b00, 6'd13, 40'h1}, 1'b0);
    chk("latched_frame", cmd_out, model_frame(6'd13, 32'hA5A5_0000));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_done_complete", complete, 1);
      chk("hold_no_restart", strobe_out, 0);
      chk("hold_not_idle", idle, 0);
    end
    finish_cmd();

    // Randomized commands against the model
    for (int n = 0; n < 20; n++) begin
      logic [5:0]  ri, rsp_i;
      logic [31:0] ra;
      logic [47:0] rr;
      int          w;
      ri = 6'($urandom_range(0, 63));
      ra = $urandom;
      rsp_i = ($urandom_range(0, 1) == 1) ? ri : 6'($urandom_range(0, 63));
      rr = {$urandom, $urandom};
      rr[45:40] = rsp_i;
      start_cmd(ri, ra, model_frame(ri, ra));
      w = $urandom_range(0, 3);
      for (int k = 0; k < w; k++) begin
        step();
        chk("rnd_wait_strobe", strobe_out, 1);
      end
      do_ack();
      do_resp(rr, rsp_i != ri);
      finish_cmd();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
